// File: rtl/mem_stage.sv
// MEM pipeline stage: runs handshaked accesses to an asynchronous 16-bit SRAM,
// stalls upstream with `hold` while an access is in flight, and registers the
// write-back bundle (value, register address, write enable) for the WB stage.
module mem_stage #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     mem_write_value,
    output logic                  hold,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_data_out,
    output logic                  ram_data_drive,
    input  logic [DATA_W-1:0]     ram_data_in,
    output logic                  ram_en_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic                  wb_valid,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [DATA_W-1:0]     wb_value
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_RECOVER
    } state_t;

    // Counter value on the final READ / WR_PULSE cycle.
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    wb_valid_q, wb_valid_d;
    logic                    reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]       wb_value_q, wb_value_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]       ram_dout_q, ram_dout_d;
    logic                    ram_drive_q, ram_drive_d;
    logic                    ram_en_n_q, ram_en_n_d;
    logic                    ram_oe_n_q, ram_oe_n_d;
    logic                    ram_we_n_q, ram_we_n_d;
    logic                    hold_raw;

    logic start_read;
    logic start_write;

    // A read wins when both mem_read and mem_write are set.
    assign start_read  = in_valid & mem_read;
    assign start_write = in_valid & mem_write & ~mem_read;

    // Next-state, SRAM strobes, write-back bundle and raw stall request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        wb_value_d  = wb_value_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_drive_d = ram_drive_q;
        ram_en_n_d  = ram_en_n_q;
        ram_oe_n_d  = ram_oe_n_q;
        ram_we_n_d  = ram_we_n_q;
        hold_raw    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_read) begin
                    hold_raw   = 1'b1;
                    ram_addr_d = ADDR_W'(alu_result);
                    ram_en_n_d = 1'b0;
                    ram_oe_n_d = 1'b0;
                    cnt_d      = 3'd0;
                    state_d    = READ;
                end else if (start_write) begin
                    hold_raw    = 1'b1;
                    ram_addr_d  = ADDR_W'(alu_result);
                    ram_dout_d  = mem_write_value;
                    ram_drive_d = 1'b1;
                    ram_en_n_d  = 1'b0;
                    ram_we_n_d  = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = WR_SETUP;
                end else begin
                    wb_valid_d  = in_valid;
                    reg_write_d = reg_write & in_valid;
                    reg_addr_d  = reg_addr;
                    wb_value_d  = alu_result;
                end
            end
            READ: begin
                if (cnt_q == LAST_CNT) begin
                    // Final read cycle: upstream advances on this same edge.
                    wb_value_d  = ram_data_in;
                    wb_valid_d  = 1'b1;
                    reg_write_d = reg_write;
                    reg_addr_d  = reg_addr;
                    ram_en_n_d  = 1'b1;
                    ram_oe_n_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    hold_raw = 1'b1;
                    cnt_d    = cnt_q + 3'd1;
                end
            end
            WR_SETUP: begin
                hold_raw   = 1'b1;
                ram_we_n_d = 1'b0;
                cnt_d      = 3'd0;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                hold_raw = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    ram_we_n_d = 1'b1;
                    state_d    = WR_RECOVER;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR_RECOVER: begin
                // Address and data are still held; release the bus on this edge.
                ram_drive_d = 1'b0;
                ram_en_n_d  = 1'b1;
                wb_valid_d  = 1'b1;
                reg_write_d = 1'b0;
                reg_addr_d  = reg_addr;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is suppressed while in reset so upstream stages can reset too.
    assign hold = hold_raw & ~rst;

    // State and output registers with synchronous reset; reset aborts any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            wb_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            wb_value_q  <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_drive_q <= 1'b0;
            ram_en_n_q  <= 1'b1;
            ram_oe_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            wb_value_q  <= wb_value_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_drive_q <= ram_drive_d;
            ram_en_n_q  <= ram_en_n_d;
            ram_oe_n_q  <= ram_oe_n_d;
            ram_we_n_q  <= ram_we_n_d;
        end
    end

    assign ram_addr       = ram_addr_q;
    assign ram_data_out   = ram_dout_q;
    assign ram_data_drive = ram_drive_q;
    assign ram_en_n       = ram_en_n_q;
    assign ram_oe_n       = ram_oe_n_q;
    assign ram_we_n       = ram_we_n_q;
    assign wb_valid       = wb_valid_q;
    assign reg_write_out  = reg_write_q;
    assign reg_addr_out   = reg_addr_q;
    assign wb_value       = wb_value_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (WAIT_CYCLES = 0, 1, 3) share the
// upstream bus; each has a private in_valid and its own SRAM model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_clr = 1'b1;
    logic        iv [3];
    logic        mem_read, mem_write, reg_write;
    logic [3:0]  reg_addr;
    logic [15:0] alu_result, wval;

    logic        hold_w [3];
    logic [17:0] addr_w [3];
    logic [15:0] dout_w [3];
    logic [15:0] din_w [3];
    logic        drive_w [3];
    logic        en_w [3];
    logic        oe_w [3];
    logic        we_w [3];
    logic        wbvld_w [3];
    logic        rwo_w [3];
    logic [3:0]  rao_w [3];
    logic [15:0] wbv_w [3];

    logic [15:0] sram [3][256];
    logic        wflag [3][256];

    typedef struct {
        logic        rw;
        logic [3:0]  ra;
        logic [15:0] val;
        logic        chkval;
    } exp_t;
    exp_t sbq [$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : gen_dut
        mem_stage #(
            .ADDR_W(18), .DATA_W(16), .REG_ADDR_W(4),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]),
            .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
            .reg_addr(reg_addr), .alu_result(alu_result), .mem_write_value(wval),
            .hold(hold_w[g]), .ram_addr(addr_w[g]), .ram_data_out(dout_w[g]),
            .ram_data_drive(drive_w[g]), .ram_data_in(din_w[g]),
            .ram_en_n(en_w[g]), .ram_oe_n(oe_w[g]), .ram_we_n(we_w[g]),
            .wb_valid(wbvld_w[g]), .reg_write_out(rwo_w[g]),
            .reg_addr_out(rao_w[g]), .wb_value(wbv_w[g])
        );
    end

    // Contents of never-written SRAM words.
    function automatic logic [15:0] fill(input logic [17:0] a);
        return (a == 18'h08001) ? 16'hBEEF : {a[7:0], ~a[7:0]};
    endfunction

    // Asynchronous SRAM read port.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            din_w[k] = 16'h0000;
            if (!en_w[k] && !oe_w[k])
                din_w[k] = wflag[k][addr_w[k][7:0]] ? sram[k][addr_w[k][7:0]] : fill(addr_w[k]);
        end
    end

    // SRAM write port: stores while enable and write strobe are both low.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sram_clr) begin
                for (int i = 0; i < 256; i++) wflag[k][i] <= 1'b0;
            end else if (!en_w[k] && !we_w[k]) begin
                sram[k][addr_w[k][7:0]] <= dout_w[k];
                wflag[k][addr_w[k][7:0]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus invariants, checked every cycle on every instance.
    logic        prev_we_low [3];
    logic [17:0] prev_addr [3];
    logic [15:0] prev_dout [3];
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("inv_oe_we", oe_w[k] | we_w[k], 1'b1);
            chk("inv_drive_oe", drive_w[k] & ~oe_w[k], 1'b0);
            if (!we_w[k] && prev_we_low[k] === 1'b1) begin
                chk("inv_addr_stable", addr_w[k], prev_addr[k]);
                chk("inv_data_stable", dout_w[k], prev_dout[k]);
            end
            prev_we_low[k] <= ~we_w[k];
            prev_addr[k]   <= addr_w[k];
            prev_dout[k]   <= dout_w[k];
        end
    end

    task automatic idle();
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store, 3 = bubble (store with in_valid = 0).
    // Called at a negedge; returns at the negedge after the op retires.
    task automatic run_op(input int k, input int kind, input logic [15:0] a,
                          input logic [15:0] v, input logic [3:0] ra,
                          input logic rw, input logic [15:0] exp_val);
        exp_t e;
        int   wc, exp_hold, nh, noe, nwe;
        logic done;
        wc = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        iv[k]      = (kind != 3);
        mem_read   = (kind == 1);
        mem_write  = (kind == 2) || (kind == 3);
        reg_write  = rw;
        reg_addr   = ra;
        alu_result = a;
        wval       = v;
        if (kind != 3) begin
            e.rw     = (kind == 2) ? 1'b0 : rw;
            e.ra     = ra;
            e.val    = (kind == 1) ? exp_val : a;
            e.chkval = (kind != 2);
            sbq.push_back(e);
        end
        exp_hold = (kind == 1) ? wc + 1 : ((kind == 2) ? wc + 3 : 0);
        nh = 0; noe = 0; nwe = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!oe_w[k]) noe++;
            if (!we_w[k]) nwe++;
            if (!en_w[k]) chk("ram_addr", addr_w[k], {2'b00, a});
            if (drive_w[k]) chk("ram_data_out", dout_w[k], v);
            if (hold_w[k]) begin
                nh++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk("op_done", done, 1'b1);
        chk("hold_cycles", nh, exp_hold);
        chk("oe_low_cycles", noe, (kind == 1) ? wc + 1 : 0);
        chk("we_low_cycles", nwe, (kind == 2) ? wc + 1 : 0);
        @(negedge clk);
        chk("wb_valid", wbvld_w[k], (kind != 3));
        if (kind == 3) chk("bubble_rwo", rwo_w[k], 1'b0);
        if (wbvld_w[k] === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("reg_write_out", rwo_w[k], e.rw);
            chk("reg_addr_out", rao_w[k], e.ra);
            if (e.chkval) chk("wb_value", wbv_w[k], e.val);
        end
        chk("post_en_n", en_w[k], 1'b1);
        chk("post_oe_n", oe_w[k], 1'b1);
        chk("post_we_n", we_w[k], 1'b1);
        chk("post_drive", drive_w[k], 1'b0);
    endtask

    initial begin
        int n;
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        reg_addr = 4'd0; alu_result = 16'h0; wval = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_hold", hold_w[k], 1'b0);
            chk("rst_wb_valid", wbvld_w[k], 1'b0);
            chk("rst_rwo", rwo_w[k], 1'b0);
            chk("rst_rao", rao_w[k], 4'd0);
            chk("rst_wbv", wbv_w[k], 16'h0);
            chk("rst_addr", addr_w[k], 18'h0);
            chk("rst_dout", dout_w[k], 16'h0);
            chk("rst_drive", drive_w[k], 1'b0);
            chk("rst_en_n", en_w[k], 1'b1);
            chk("rst_oe_n", oe_w[k], 1'b1);
            chk("rst_we_n", we_w[k], 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        sram_clr = 1'b0;

        run_op(1, 0, 16'h0010, 16'h0000, 4'd3, 1'b1, 16'h0000);
        idle();
        run_op(1, 1, 16'h8001, 16'h0000, 4'd5, 1'b1, 16'hBEEF);
        idle();
        run_op(1, 2, 16'h00FF, 16'h1234, 4'd9, 1'b1, 16'h0000);
        chk("sram_00FF", sram[1][8'hFF], 16'h1234);
        idle();
        run_op(1, 2, 16'h0040, 16'h5678, 4'd2, 1'b0, 16'h0000);
        run_op(1, 1, 16'h0040, 16'h0000, 4'd7, 1'b1, 16'h5678);
        idle();
        run_op(0, 1, 16'h0021, 16'h0000, 4'd4, 1'b1, fill(18'h00021));
        run_op(0, 2, 16'h0022, 16'hCAFE, 4'd1, 1'b0, 16'h0000);
        idle();
        chk("sram_w0_0022", sram[0][8'h22], 16'hCAFE);
        run_op(2, 1, 16'h0031, 16'h0000, 4'd8, 1'b1, fill(18'h00031));
        run_op(2, 2, 16'h0032, 16'h0F0F, 4'd1, 1'b0, 16'h0000);
        idle();
        chk("sram_w3_0032", sram[2][8'h32], 16'h0F0F);
        run_op(1, 3, 16'h0050, 16'hDEAD, 4'd6, 1'b1, 16'h0000);
        chk("bubble_no_write", wflag[1][8'h50], 1'b0);
        idle();

        // Reset while the write strobe is low.
        iv[2] = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
        alu_result = 16'h0033; wval = 16'hAAAA; reg_write = 1'b0; reg_addr = 4'd0;
        n = 0;
        #1;
        while (we_w[2] !== 1'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_reached_pulse", we_w[2], 1'b0);
        rst = 1'b1;
        #1;
        chk("hold_in_rst", hold_w[2], 1'b0);
        @(negedge clk);
        iv[2] = 1'b0; mem_write = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_we_n", we_w[2], 1'b1);
        chk("abort_en_n", en_w[2], 1'b1);
        chk("abort_drive", drive_w[2], 1'b0);
        chk("abort_wb_valid", wbvld_w[2], 1'b0);
        chk("abort_hold", hold_w[2], 1'b0);
        @(negedge clk);
        run_op(2, 0, 16'h7777, 16'h0000, 4'd12, 1'b1, 16'h0000);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. It sits directly downstream of the ID/EXE register and the ALU. It consumes the ALU result, the memory controls and the store value.
- It runs multi-cycle accesses to the single asynchronous 16-bit SRAM through a handshake state machine. While an access is in flight it stalls the upstream stages with `hold`.
- It registers the write-back bundle (value, register address, write enable) for the WB stage.

Parameters:
- ADDR_W, 18, SRAM address width; the 16-bit ALU result is zero-extended to this width.
- DATA_W, 16, register and SRAM data width.
- REG_ADDR_W, 4, register-file address width.
- WAIT_CYCLES, 1, extra SRAM access cycles; legal range 0..7.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  EXE result present (0 = bubble)
- mem_read  in  1  load
- mem_write  in  1  store
- reg_write  in  1  instruction writes the register file
- reg_addr  in  REG_ADDR_W  destination register
- alu_result  in  DATA_W  ALU result, or memory address for loads/stores
- mem_write_value  in  DATA_W  store data
- hold  out  1  stall request to the PC, IF/ID and ID/EXE stages (combinational)
- ram_addr  out  ADDR_W  SRAM address
- ram_data_out  out  DATA_W  SRAM write data
- ram_data_drive  out  1  tristate enable for ram_data_out
- ram_data_in  in  DATA_W  SRAM read data
- ram_en_n  out  1  SRAM chip enable, active low
- ram_oe_n  out  1  SRAM output enable, active low
- ram_we_n  out  1  SRAM write enable, active low
- wb_valid  out  1  write-back bundle valid
- reg_write_out  out  1  registered reg_write
- reg_addr_out  out  REG_ADDR_W  registered reg_addr
- wb_value  out  DATA_W  value to write back

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous, active-high.
- Reset values:
  - wb_valid, reg_write_out, ram_data_drive = 0
  - reg_addr_out, wb_value, ram_addr, ram_data_out = 0
  - ram_en_n, ram_oe_n, ram_we_n = 1
  - FSM = IDLE, wait counter = 0
- hold is 0 whenever rst = 1. Reset mid-access aborts the access: strobes are deasserted on that edge and no write-back occurs.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_RECOVER.
- If mem_read and mem_write are both 1, the op is treated as a read.
- Non-memory op in IDLE:
  - hold = 0.
  - Next edge: wb_valid = in_valid, reg_write_out = reg_write & in_valid, reg_addr_out = reg_addr, wb_value = alu_result.
  - Latency 1 cycle.
- Read accepted in IDLE (cycle T0):
  - hold = 1 during T0.
  - Edge end of T0: ram_addr = zero-extended alu_result, ram_en_n = 0, ram_oe_n = 0, counter = 0, go to READ. wb_valid = 0.
  - READ lasts WAIT_CYCLES+1 cycles; the counter increments each cycle.
  - hold = 1 in READ except on its last cycle (counter == WAIT_CYCLES), where hold = 0 so upstream advances on the same edge.
  - Edge ending the last READ cycle:
    - wb_value = ram_data_in, wb_valid = 1, reg_write_out = reg_write, reg_addr_out = reg_addr
    - ram_en_n = 1, ram_oe_n = 1, go to IDLE
  - Total occupancy: WAIT_CYCLES+2 cycles.
- Write accepted in IDLE (cycle T0):
  - hold = 1.
  - Edge: latch ram_addr; ram_data_out = mem_write_value, ram_data_drive = 1, ram_en_n = 0, ram_we_n = 1; go to WR_SETUP.
  - WR_SETUP: 1 cycle, hold = 1. Then ram_we_n = 0 and go to WR_PULSE.
  - WR_PULSE: WAIT_CYCLES+1 cycles, hold = 1. Then ram_we_n = 1 and go to WR_RECOVER.
  - WR_RECOVER: 1 cycle. Address and data stay stable, hold = 0.
  - Edge ending WR_RECOVER: ram_data_drive = 0, ram_en_n = 1, go to IDLE.
  - wb_valid = 1 with reg_write_out = 0 (store retires without write-back).
  - Total occupancy: WAIT_CYCLES+4 cycles.
- Invariants:
  - ram_oe_n and ram_we_n are never 0 simultaneously.
  - ram_data_drive is never 1 while ram_oe_n = 0.
  - ram_addr and ram_data_out are stable whenever ram_we_n = 0.
- Upstream inputs are sampled only in IDLE and on the final (hold = 0) cycle; they are stable meanwhile because of the hold.
- After an op completes, the next op is accepted only in the following IDLE cycle; there is no overlap.
- in_valid = 0 in IDLE produces a bubble: wb_valid = 0, reg_write_out = 0, no SRAM activity.

Test Plan:
- Reset, then ADDIU result: in_valid = 1, reg_write = 1, reg_addr = 3, alu_result = 0x0010 -> next edge wb_valid = 1, reg_write_out = 1, reg_addr_out = 3, wb_value = 0x0010, hold = 0 throughout.
- Load, WAIT_CYCLES = 1: mem_read, alu_result = 0x8001, reg_addr = 5, SRAM model returns 0xBEEF -> hold high for 2 cycles then low for 1; ram_addr = 0x08001; ram_oe_n low 2 cycles; wb_value = 0xBEEF, reg_addr_out = 5 three edges after presentation.
- Store: mem_write, alu_result = 0x00FF, mem_write_value = 0x1234 -> setup 1 cycle, ram_we_n low exactly 2 cycles, data and address stable through recover; SRAM location 0x000FF = 0x1234; reg_write_out = 0; hold high 4 cycles, low on the 5th.
- Back-to-back store then load, same address 0x0040 -> load returns the stored 0x5678; no cycle with oe_n = 0 and we_n = 0, nor with drive = 1 and oe_n = 0.
- rst asserted during WR_PULSE -> next edge: we_n = 1, en_n = 1, drive = 0, FSM IDLE, wb_valid = 0, hold = 0.
- WAIT_CYCLES = 0 and 3, plus a bubble (in_valid = 0) -> read occupancy 2/5 cycles, write 4/7 cycles; bubble yields wb_valid = 0 and no strobes.
